// File: rtl/muldiv_ctrl_pkg.sv
// Shared operation codes, sequencer states and small helpers for the multiply/divide sequencer.
package muldiv_ctrl_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

   // Encoding puts divide in bit 1 and "unsigned" in bit 0.
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
   parameter int ITERS = 32
) (
   input  logic [2*ITERS-1:0] part,
   input  logic [ITERS-1:0]   operand,
   input  logic               div_mode,
   output logic [2*ITERS-1:0] next_part,
   output logic               qbit
);

   logic [ITERS:0] sum;
   logic [ITERS:0] rem_sh;
   logic [ITERS:0] trial;

   always_comb begin
      sum       = {1'b0, part[2*ITERS-1:ITERS]} + (part[0] ? {1'b0, operand} : '0);
      rem_sh    = part[2*ITERS-1:ITERS-1];
      trial     = rem_sh - {1'b0, operand};
      qbit      = 1'b0;
      next_part = '0;
      if (div_mode) begin
         // No borrow out of the trial subtract means the divisor fits.
         qbit      = ~trial[ITERS];
         next_part = {(qbit ? trial[ITERS-1:0] : rem_sh[ITERS-1:0]), part[ITERS-2:0], 1'b0};
      end else begin
         next_part = {sum, part[ITERS-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int ITERS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] LAST = 6'(ITERS - 1);

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction

   md_state_e   state, state_nxt;
   logic [5:0]  cnt;
   logic [63:0] acc;
   logic [31:0] mag_b_r;
   logic [31:0] a_orig;
   logic        is_div, neg_res, neg_rem, divzero;

   logic        sgn, sa, sb;
   logic [31:0] mag_a, mag_b;
   logic [63:0] step_out;
   logic        step_q;
   logic [63:0] prod;
   logic [31:0] quo, rem;
   logic [31:0] fix_hi, fix_lo;

   muldiv_step #(.ITERS(ITERS)) u_step (
      .part      (acc),
      .operand   (mag_b_r),
      .div_mode  (is_div),
      .next_part (step_out),
      .qbit      (step_q)
   );

   assign busy = (state != MD_IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (start) state_nxt = MD_RUN;
         MD_RUN:  if (cnt == LAST) state_nxt = MD_FIX;
         MD_FIX:  state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_comb begin
      sgn   = op_is_signed(op);
      sa    = sgn & A[31];
      sb    = sgn & B[31];
      mag_a = sa ? neg32(A) : A;
      mag_b = sb ? neg32(B) : B;
   end

   always_comb begin
      prod   = neg_res ? neg64(acc) : acc;
      quo    = neg_res ? neg32(acc[31:0]) : acc[31:0];
      rem    = neg_rem ? neg32(acc[63:32]) : acc[63:32];
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
      if (divzero) begin
         fix_hi = a_orig;
         fix_lo = 32'hFFFF_FFFF;
      end else if (is_div) begin
         fix_hi = rem;
         fix_lo = quo;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
         cnt  <= '0;
      end else begin
         done <= (state == MD_FIX);
         case (state)
            MD_IDLE: begin
               if (start) begin
                  // A start in IDLE takes priority over a coincident MTHI/MTLO.
                  acc     <= {32'd0, mag_a};
                  mag_b_r <= mag_b;
                  a_orig  <= A;
                  is_div  <= op_is_div(op);
                  neg_res <= sa ^ sb;
                  neg_rem <= sa & op_is_div(op);
                  divzero <= op_is_div(op) & (B == 32'd0);
                  cnt     <= '0;
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            MD_RUN: begin
               acc <= is_div ? {step_out[63:1], step_q} : step_out;
               cnt <= cnt + 6'd1;
            end
            MD_FIX: begin
               hi <= fix_hi;
               lo <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for the multiply/divide sequencer with hand-computed results.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] A, B;
   logic        mthi, mtlo;
   logic [31:0] wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_ctrl dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launches an operation at edge 0 and follows it until done (bounded).
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inj, input bit mtlo_with_start,
                         output int lat, output bit busy_ok);
      op = o; A = a; B = b; start = 1'b1; mtlo = mtlo_with_start; wdata = 32'h0000_0055;
      tick();
      start = 1'b0; mtlo = 1'b0;
      lat = 0; busy_ok = 1'b1;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (inj && cyc == 10) begin
            start = 1'b1; op = 2'd1; A = 32'd5; B = 32'd5; mthi = 1'b1; wdata = 32'h0000_DEAD;
         end
         if (inj && cyc == 11) begin
            start = 1'b0; mthi = 1'b0;
         end
         if (busy !== (cyc <= 33)) busy_ok = 1'b0;
         if (done === 1'b1) begin
            lat = cyc;
            break;
         end
         tick();
      end
   endtask

   int lat;
   bit bok;
   bit seen_done;

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'd0; A = '0; B = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;
      tick(); tick();
      rst = 1'b0;
      check_eq("reset_busy", 64'(busy), 64'd0);
      check_eq("reset_done", 64'(done), 64'd0);
      check_eq("reset_hi", 64'(hi), 64'd0);
      check_eq("reset_lo", 64'(lo), 64'd0);

      // MULT -3 * 7 = -21
      run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, lat, bok);
      check_eq("mult_latency", 64'(lat), 64'd34);
      check_eq("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      check_eq("mult_lo", 64'(lo), 64'hFFFF_FFEB);
      tick();
      check_eq("mult_done_one_cycle", 64'(done), 64'd0);

      // MULTU 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bok);
      check_eq("multu_latency", 64'(lat), 64'd34);
      check_eq("multu_busy_window", 64'(bok), 64'd1);
      check_eq("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      check_eq("multu_lo", 64'(lo), 64'h0000_0001);
      tick();

      // DIV -7 / 2 -> q=-3, r=-1
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, lat, bok);
      check_eq("div_neg_latency", 64'(lat), 64'd34);
      check_eq("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
      check_eq("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
      tick();

      // DIV most-negative / -1
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bok);
      check_eq("div_ovf_lo", 64'(lo), 64'h8000_0000);
      check_eq("div_ovf_hi", 64'(hi), 64'd0);
      tick();

      // DIVU by zero
      run_op(2'd3, 32'h0000_1234, 32'd0, 1'b0, 1'b0, lat, bok);
      check_eq("divz_latency", 64'(lat), 64'd34);
      check_eq("divz_hi", 64'(hi), 64'h0000_1234);
      check_eq("divz_lo", 64'(lo), 64'hFFFF_FFFF);
      tick();

      // DIV by zero with a negative dividend keeps the raw dividend in HI
      run_op(2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, lat, bok);
      check_eq("divz_signed_hi", 64'(hi), 64'hFFFF_FFF9);
      check_eq("divz_signed_lo", 64'(lo), 64'hFFFF_FFFF);
      tick();

      // DIVU 100 / 7 -> q=14, r=2
      run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, lat, bok);
      check_eq("divu_lo", 64'(lo), 64'd14);
      check_eq("divu_hi", 64'(hi), 64'd2);
      tick();

      // MULT 6*7 with start and mthi pulsed while busy
      run_op(2'd0, 32'd6, 32'd7, 1'b1, 1'b0, lat, bok);
      check_eq("conflict_latency", 64'(lat), 64'd34);
      check_eq("conflict_busy_window", 64'(bok), 64'd1);
      check_eq("conflict_hi", 64'(hi), 64'd0);
      check_eq("conflict_lo", 64'(lo), 64'd42);
      tick();
      check_eq("conflict_no_relaunch", 64'(busy), 64'd0);

      // mthi + mtlo together in IDLE
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      check_eq("mthilo_hi", 64'(hi), 64'hA5A5_A5A5);
      check_eq("mthilo_lo", 64'(lo), 64'hA5A5_A5A5);

      // start + mtlo in IDLE: the operation wins
      op = 2'd1; A = 32'd3; B = 32'd4; start = 1'b1; mtlo = 1'b1; wdata = 32'h0000_0055;
      tick();
      start = 1'b0; mtlo = 1'b0;
      check_eq("startmtlo_hold_lo", 64'(lo), 64'hA5A5_A5A5);
      lat = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (done === 1'b1) begin
            lat = cyc;
            break;
         end
         tick();
      end
      check_eq("startmtlo_latency", 64'(lat), 64'd34);
      check_eq("startmtlo_lo", 64'(lo), 64'd12);
      check_eq("startmtlo_hi", 64'(hi), 64'd0);
      tick();

      // Reset in the middle of a DIVU aborts it
      mthi = 1'b1; wdata = 32'h0000_0077;
      tick();
      mthi = 1'b0;
      check_eq("mthi_only", 64'(hi), 64'h0000_0077);
      op = 2'd3; A = 32'd100; B = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_hi", 64'(hi), 64'd0);
      check_eq("abort_lo", 64'(lo), 64'd0);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (done === 1'b1) seen_done = 1'b1;
         tick();
      end
      check_eq("abort_no_done", 64'(seen_done), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
